// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states
// and the accept-time legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, RMW_WR} lsu_state_t;

  // Flags illegal funct3 for the access direction, or an access not aligned to its size.
  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic legal;
    logic misal;
    if (we) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    misal = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    return !legal || misal;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Lane select with sign/zero extension for loads; the lane mask output marks
// the same lane in place for store read-modify-write merges.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o,
  output logic [31:0] lane_mask_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'(word_i >> {off_i, 3'b000});
    half_v = 16'(word_i >> {off_i[1], 4'b0000});

    case (funct3_i)
      F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data_o = {24'd0, byte_v};
      F3_H:    data_o = {{16{half_v[15]}}, half_v};
      F3_HU:   data_o = {16'd0, half_v};
      default: data_o = word_i;
    endcase

    case (funct3_i[1:0])
      2'b00:   lane_mask_o = 32'h0000_00FF << {off_i, 3'b000};
      2'b01:   lane_mask_o = 32'h0000_FFFF << {off_i[1], 4'b0000};
      default: lane_mask_o = '1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide data memory; sub-word stores
// are performed as a two-cycle read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned A = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [2:0]   req_funct3,
  input  logic [A-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err,
  output logic         mem_we,
  output logic [A-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata
);

  lsu_state_t   state_q, state_d;
  logic         resp_valid_q, resp_valid_d;
  logic         resp_err_q, resp_err_d;
  logic [N-1:0] resp_rdata_q, resp_rdata_d;
  logic [A-1:0] rmw_addr_q, rmw_addr_d;
  logic [N-1:0] rmw_data_q, rmw_data_d;

  logic         accept;
  logic         acc_err;
  logic [A-1:0] aligned_addr;
  logic [N-1:0] load_data;
  logic [N-1:0] lane_mask;
  logic [N-1:0] wdata_rep;

  assign aligned_addr = {req_addr[A-1:2], 2'b00};
  // Replicating the store data lets the lane mask alone pick the target lane.
  assign wdata_rep = (req_funct3[1:0] == 2'b00) ? {4{req_wdata[7:0]}} : {2{req_wdata[15:0]}};

  lsu_load_align u_align (
    .word_i      (mem_rdata),
    .off_i       (req_addr[1:0]),
    .funct3_i    (req_funct3),
    .data_o      (load_data),
    .lane_mask_o (lane_mask)
  );

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    rmw_addr_d   = rmw_addr_q;
    rmw_data_d   = rmw_data_q;
    req_ready    = rst && (state_q == IDLE);
    accept       = req_valid && req_ready;
    acc_err      = access_err(req_we, req_funct3, req_addr[1:0]);
    mem_we       = 1'b0;
    mem_addr     = aligned_addr;
    mem_wdata    = req_wdata;

    case (state_q)
      IDLE: begin
        if (accept) begin
          resp_valid_d = 1'b1;
          if (acc_err) begin
            resp_err_d = 1'b1;
          end else if (!req_we) begin
            resp_rdata_d = load_data;
          end else if (req_funct3 == F3_W) begin
            mem_we = 1'b1;
          end else begin
            resp_valid_d = 1'b0;
            rmw_addr_d   = aligned_addr;
            rmw_data_d   = (mem_rdata & ~lane_mask) | (wdata_rep & lane_mask);
            state_d      = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        // Gating with rst lets a reset in this cycle abort the pending write.
        mem_we       = rst;
        mem_addr     = rmw_addr_q;
        mem_wdata    = rmw_data_q;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      rmw_addr_q   <= '0;
      rmw_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      rmw_addr_q   <= rmw_addr_d;
      rmw_data_q   <= rmw_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the execute stage and the word-organised data memory: accepts one load or store per request and translates RV32I byte/halfword/word accesses into whole-word memory operations. Loads read the aligned word, then select the addressed lane and sign- or zero-extend it. SB/SH stores run a two-cycle read-modify-write, because the memory only writes full words. Misaligned and unsupported accesses are rejected without touching memory.

## Interface
- N, 32, data width (fixed at 32 for RV32I lanes)
- A, 10, byte-address width presented to data memory

- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (sampled at posedge clk)
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at posedge
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  A  byte address
- req_wdata  in  N  store data (low byte/half used for SB/SH)
- resp_valid  out  1  one-cycle pulse, request complete
- resp_rdata  out  N  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned or illegal funct3
- mem_we  out  1  memory write enable
- mem_addr  out  A  word-aligned byte address, {addr[A-1:2], 2'b00}
- mem_wdata  out  N  full word to write
- mem_rdata  in  N  combinational read of mem_addr, same cycle

## Operation
- FSM states: IDLE, RMW_WR.
- req_ready = 1 in IDLE, 0 in RMW_WR.
- Error check at accept:
  - LH/LHU/SH with addr[0] = 1 is misaligned.
  - LW/SW with addr[1:0] != 0 is misaligned.
  - Loads with funct3 3, 6 or 7 and stores with funct3 > 2 are illegal.
  - On error: no mem_we, and the next cycle gives resp_valid = 1, resp_err = 1, resp_rdata = 0.
- Load (IDLE accept): mem_addr = aligned address.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
  - Result is registered into resp_rdata.
- SW (IDLE accept): mem_we = 1, mem_wdata = req_wdata, same cycle.
- SB/SH (IDLE accept): mem_we = 0.
  - Merge mem_rdata with req_wdata[7:0] or [15:0] at the addressed lane.
  - Capture the merged word and aligned address in registers, then go to RMW_WR.
- RMW_WR: mem_we = 1, with mem_addr and mem_wdata taken from the captured registers; then return to IDLE.
- Stores return resp_rdata = 0, resp_err = 0.
- mem_we is never asserted while rst = 0, and never in IDLE without an accepted legal SW.

## Timing
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, mem_we 0, merge registers 0. req_ready is 0 while rst = 0.
- Load, SW and error requests: resp_valid one cycle after accept (latency 1).
- SB/SH: accept in cycle T, write in T+1, resp_valid in T+2; req_ready = 0 during T+1.
- Back-to-back: a new request may be accepted in the same cycle resp_valid is high.
- A load accepted in the cycle after an RMW write returns the newly written word. The memory write commits at that posedge, and the read is combinational.
- Reset asserted in RMW_WR aborts the write: mem_we = 0, and no resp_valid is produced.
- Inputs are sampled only on accept; changes to req_* during RMW_WR are ignored.

## Structure
- Package lsu_pkg:
  - funct3 constants F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101.
  - State enum lsu_state_t {IDLE, RMW_WR}.
- Sub-module lsu_load_align: combinational lane select plus sign/zero extension, from (word, addr[1:0], funct3) to extended data. It is also reused for store-lane merge masks.
- Top level holds the FSM, response registers and merge registers.

## Test plan
- Preload 0x8899AABB at word addr 0x010.
  - LB addr 0x013 → resp_rdata 0xFFFFFF88.
  - LBU addr 0x013 → 0x00000088.
  - LH addr 0x012 → 0xFFFF8899.
  - LHU addr 0x010 → 0x0000AABB.
- SB wdata 0x12345677 at 0x011 on word 0x8899AABB:
  - req_ready low one cycle, single mem_we with wdata 0x889977BB.
  - resp_valid at T+2; subsequent LW 0x010 → 0x889977BB.
- SW 0xDEADBEEF at 0x020: mem_we in the accept cycle, resp_valid next cycle; LW 0x020 → 0xDEADBEEF.
- LW at 0x022, SH at 0x021, funct3 = 3 load → resp_err = 1, resp_rdata = 0, mem_we never high.
- Reset:
  - Drop rst during RMW_WR of SH 0xCAFE to 0x030 → no write; word 0x030 keeps its old value.
  - All response outputs are 0 the cycle after reset.
